// File: rtl/alu_issue_ctrl.sv
// Decode-and-issue stage for the 3-bit-control ALU: decodes RV32 R/I ops, registers
// operands toward the ALU, captures its result and hands it downstream.
module alu_issue_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal,
    output logic [15:0]     retired_cnt
);

    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned CNT_W   = 16;
    localparam logic [6:0]  OPC_R   = 7'b0110011;
    localparam logic [6:0]  OPC_I   = 7'b0010011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state, state_nxt;
    logic            is_r, is_i;
    logic            dec_legal;
    logic            dec_shift;
    logic [2:0]      dec_ctrl;
    logic [XLEN-1:0] b_src;
    logic [XLEN-1:0] dec_b;
    logic            accept;

    // Opcode/funct decode into ALU function select and operand b
    always_comb begin
        is_r      = (opcode == OPC_R);
        is_i      = (opcode == OPC_I);
        b_src     = is_r ? rs2_val : imm;
        dec_legal = 1'b0;
        dec_shift = 1'b0;
        dec_ctrl  = ALU_ADD;
        if (is_r || is_i) begin
            case (funct3)
                3'b000: begin
                    dec_legal = 1'b1;
                    dec_ctrl  = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
                end
                3'b001: begin
                    dec_legal = !funct7_5;
                    dec_shift = 1'b1;
                    dec_ctrl  = ALU_SLL;
                end
                3'b101: begin
                    dec_legal = !funct7_5;
                    dec_shift = 1'b1;
                    dec_ctrl  = ALU_SRL;
                end
                3'b110: begin
                    dec_legal = 1'b1;
                    dec_ctrl  = ALU_OR;
                end
                3'b111: begin
                    dec_legal = 1'b1;
                    dec_ctrl  = ALU_AND;
                end
                3'b100: begin
                    // Only XORI with all-ones immediate maps onto the ALU (bitwise NOT)
                    dec_legal = is_i && (imm == '1);
                    dec_ctrl  = ALU_NOT;
                end
                default: begin
                    dec_legal = 1'b0;
                    dec_ctrl  = ALU_ADD;
                end
            endcase
        end
        // ALU shifts by the full b value, so trim to the RV32 shift amount
        dec_b = dec_shift ? XLEN'(b_src[SHAMT_W-1:0]) : b_src;
    end

    assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = dec_legal ? EXEC : DONE;
                end
            end
            EXEC: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_nxt = dec_legal ? EXEC : DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand registers load only for legal ops so illegal ops leave the ALU untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= ALU_ADD;
        end else if (accept && dec_legal) begin
            alu_a       <= rs1_val;
            alu_b       <= dec_b;
            alu_control <= dec_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result  <= '0;
            out_illegal <= 1'b0;
        end else if (accept && !dec_legal) begin
            out_result  <= '0;
            out_illegal <= 1'b1;
        end else if (state == EXEC) begin
            out_result  <= alu_result;
            out_illegal <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if ((state == DONE) && out_ready) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Decode-and-issue stage that drives the 3-bit-control combinational ALU and collects its result. It accepts one RV32 integer op per handshake and translates opcode/funct fields into `alu_control`. It registers the operands toward the ALU, captures the ALU result one cycle later, and presents it downstream under a valid/ready handshake. It sits between the register-read stage and writeback in the core datapath.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: upstream op valid.
- `in_ready` out 1: stage can accept an op.
- `opcode` in 7: 7'b0110011 is R-type, 7'b0010011 is I-type.
- `funct3` in 3: RV32 funct3.
- `funct7_5` in 1: instruction bit 30.
- `rs1_val` in XLEN: source 1.
- `rs2_val` in XLEN: source 2 (R-type).
- `imm` in XLEN: sign-extended I-immediate (I-type).
- `alu_a` out XLEN: registered operand to the ALU.
- `alu_b` out XLEN: registered operand to the ALU.
- `alu_control` out 3: registered ALU function select.
- `alu_result` in XLEN: combinational ALU output.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_result` out XLEN: captured result.
- `out_illegal` out 1: op not mappable to the ALU.
- `retired_cnt` out 16: count of completed output handshakes; wraps.

## Operation
- ALU encoding: 000 add, 001 sub, 010 not-a, 011 a<<b, 100 a>>b (logical), 101 and, 110 or.
- Operand b source: `rs2_val` for R-type, `imm` for I-type.
- Decode, by funct3:
  - 000: add (code 000). R-type with `funct7_5`=1 is sub (code 001). I-type is always add.
  - 001 with `funct7_5`=0: sll (code 011).
  - 101 with `funct7_5`=0: srl (code 100). `funct7_5`=1 (sra) is illegal.
  - 110: or (code 110).
  - 111: and (code 101).
  - 100: legal only for I-type with `imm`=32'hFFFFFFFF, mapped to not-a (code 010). All other 100 ops are illegal.
  - 010 and 011 (slt/sltu): illegal.
  - Any other opcode: illegal.
- Shift ops: `alu_b` is driven as {27'b0, b[4:0]}. The ALU shifts by the full value of b, so the masking is required for RV32 semantics.
- FSM states:
  - IDLE: `in_ready`=1. Accepting a legal op goes to EXEC. Accepting an illegal op goes to DONE.
  - EXEC: one cycle. Captures `alu_result` into `out_result`, clears `out_illegal`, and goes to DONE.
  - DONE: `out_valid`=1. On `out_ready`=1, increments `retired_cnt`. If `in_valid` is also 1, accepts the new op and goes to EXEC or DONE per its legality. Otherwise goes to IDLE.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready).
- Illegal op: `out_result`=0 and `out_illegal`=1. `alu_a`, `alu_b` and `alu_control` keep their previous values.
- `alu_a`, `alu_b` and `alu_control` load only on an accepted legal op.
- `out_result` and `out_illegal` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset: state IDLE; every output, including `retired_cnt`, is 0. `alu_control`=000. `in_ready` rises only after `rst_n` is deasserted.
- Legal op accepted at edge N:
  - operands reach the ALU after edge N;
  - the result is captured at edge N+1;
  - `out_valid`=1 after edge N+1.
- Illegal op accepted at edge N: `out_valid`=1 after edge N.
- Back-to-back legal ops with `out_ready` held at 1: one result every 2 cycles.
- `rst_n` asserted mid-op (EXEC or DONE): state and outputs clear immediately with no clock required. The pending result is dropped and `retired_cnt` does not increment.
- `retired_cnt` wraps from 16'hFFFF to 0.

## Test plan
- ADD: R-type, funct3 000, `rs1_val`=5, `rs2_val`=7, accepted at edge N. Required: `alu_control`=000; `out_valid` high after N+1 with `out_result`=12; `retired_cnt`=1 after the handshake.
- SUB then SLLI, back-to-back, `out_ready`=1:
  - SUB: 10-3 with `funct7_5`=1 gives `out_result`=7.
  - SLLI: `rs1_val`=1, `imm`=33 gives `alu_b`=1 and `out_result`=2.
  - Second accept happens in the DONE cycle of the first; results are 2 cycles apart.
- NOT via XORI: `imm`=32'hFFFFFFFF, `rs1_val`=32'h0F0F0F0F. Required: `alu_control`=010, `out_result`=32'hF0F0F0F0. XORI with `imm`=1 gives `out_illegal`=1 and `out_result`=0.
- Illegal SRA and SLT: `out_valid` high one edge after accept, `out_illegal`=1, `out_result`=0, `alu_control` unchanged.
- Back-pressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1. Required: `in_ready`=0 and `out_result` stable throughout; on `out_ready`=1 the next op is accepted in that same cycle.
- Reset in EXEC: drop `rst_n` between edges. Required: `out_valid`, `in_ready` and `retired_cnt` go to 0 immediately; after release, a fresh ADD completes normally.
